// File: rtl/boot_jump_ctrl.sv
// Post-reset boot sequencer: feeds JP JUMP_TARGET to the Z80 on its first three
// valid reads, then raises reset_cs so the address decoder enables normal RAM/ROM.
module boot_jump_ctrl #(
    parameter logic [15:0] JUMP_TARGET     = 16'hF000,
    parameter int          MIN_READ_CYCLES = 2,
    parameter int          TIMEOUT_CYCLES  = 65535
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       memread,
    input  logic       memwrite,
    input  logic       m1,
    output logic       data_override,
    output logic [7:0] override_data,
    output logic       reset_cs,
    output logic       boot_done,
    output logic       boot_timeout
);

    typedef enum logic [1:0] {S_OP, S_LO, S_HI, S_RUN} state_t;

    localparam logic [3:0]  MIN_RD   = 4'(MIN_READ_CYCLES);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  rd_cnt_q, rd_cnt_d;
    logic        m1_last_q, m1_last_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  ovr_q, ovr_d;
    logic        rcs_q, rcs_d;
    logic        done_q, done_d;
    logic        tmo_flag_q, tmo_flag_d;
    logic        rd_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_OP;
            rd_cnt_q   <= 4'd0;
            m1_last_q  <= 1'b0;
            tmo_q      <= 16'd0;
            ovr_q      <= 8'hC3;
            rcs_q      <= 1'b0;
            done_q     <= 1'b0;
            tmo_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            m1_last_q  <= m1_last_d;
            tmo_q      <= tmo_d;
            ovr_q      <= ovr_d;
            rcs_q      <= rcs_d;
            done_q     <= done_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        ovr_d      = ovr_q;
        done_d     = 1'b0;
        tmo_flag_d = tmo_flag_q;

        // memwrite is deliberately ignored: only memread drives the read counter
        rd_cnt_d  = memread ? ((rd_cnt_q == 4'hF) ? 4'hF : rd_cnt_q + 4'd1) : 4'd0;
        m1_last_d = memread ? m1 : m1_last_q;
        rd_valid  = !memread && (rd_cnt_q >= MIN_RD);

        case (state_q)
            S_OP:    ovr_d = 8'hC3;
            S_LO:    ovr_d = JUMP_TARGET[7:0];
            S_HI:    ovr_d = JUMP_TARGET[15:8];
            default: ovr_d = ovr_q;
        endcase

        if (state_q != S_RUN) begin
            if (rd_valid) begin
                // any valid read restarts the watchdog, even an ignored non-M1 read in OP
                tmo_d = 16'd0;
                case (state_q)
                    S_OP:    if (m1_last_q) state_d = S_LO;
                    S_LO:    state_d = S_HI;
                    S_HI: begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end
                    default: state_d = state_q;
                endcase
            end else begin
                tmo_d = tmo_q + 16'd1;
                if (tmo_q == TMO_LAST) begin
                    state_d    = S_RUN;
                    tmo_flag_d = 1'b1;
                end
            end
        end

        rcs_d = (state_d == S_RUN);
    end

    assign data_override = memread && (state_q != S_RUN);
    assign override_data = ovr_q;
    assign reset_cs      = rcs_q;
    assign boot_done     = done_q;
    assign boot_timeout  = tmo_flag_q;

endmodule

// File: tb/tb_boot_jump_ctrl.sv
// Directed + random bench for boot_jump_ctrl against a cycle-level behavioural model.
module tb_boot_jump_ctrl;

    localparam int          TO   = 20;
    localparam int          MINR = 2;
    localparam logic [15:0] JT   = 16'hF000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       memread = 1'b0;
    logic       memwrite = 1'b0;
    logic       m1 = 1'b0;
    logic       data_override;
    logic [7:0] override_data;
    logic       reset_cs;
    logic       boot_done;
    logic       boot_timeout;

    boot_jump_ctrl #(
        .JUMP_TARGET    (JT),
        .MIN_READ_CYCLES(MINR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .memread      (memread),
        .memwrite     (memwrite),
        .m1           (m1),
        .data_override(data_override),
        .override_data(override_data),
        .reset_cs     (reset_cs),
        .boot_done    (boot_done),
        .boot_timeout (boot_timeout)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Model: phase counts completed boot bytes (3 = released)
    logic [7:0] bytes_m [3];
    int         phase = 0;
    int         rlen = 0;
    int         wdog = 0;
    bit         lastm1 = 1'b0;
    logic [7:0] e_ovr = 8'hC3;
    bit         e_done = 1'b0;
    bit         e_flag = 1'b0;
    bit         e_rcs = 1'b0;
    int         done_seen = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit mr, input bit mm);
        bit valid;
        if (rst) begin
            phase = 0; rlen = 0; wdog = 0; lastm1 = 1'b0;
            e_ovr = 8'hC3; e_done = 1'b0; e_flag = 1'b0; e_rcs = 1'b0;
            return;
        end
        e_done = 1'b0;
        if (phase < 3) e_ovr = bytes_m[phase];
        valid = !mr && (rlen >= MINR);
        if (phase < 3) begin
            if (valid) begin
                wdog = 0;
                if (phase != 0 || lastm1) begin
                    phase++;
                    if (phase == 3) e_done = 1'b1;
                end
            end else begin
                wdog++;
                if (wdog == TO) begin
                    phase  = 3;
                    e_flag = 1'b1;
                end
            end
        end
        if (mr) begin
            rlen   = (rlen < 15) ? rlen + 1 : 15;
            lastm1 = mm;
        end else begin
            rlen = 0;
        end
        e_rcs = (phase == 3);
    endtask

    task automatic cyc(input bit rst, input bit mr, input bit mw, input bit mm);
        @(negedge clock);
        reset = rst; memread = mr; memwrite = mw; m1 = mm;
        #1;
        chk("data_override", {7'd0, data_override}, {7'd0, (mr && phase < 3)});
        @(posedge clock);
        model_edge(rst, mr, mm);
        #1;
        chk("reset_cs", {7'd0, reset_cs}, {7'd0, e_rcs});
        chk("override_data", override_data, e_ovr);
        chk("boot_done", {7'd0, boot_done}, {7'd0, e_done});
        chk("boot_timeout", {7'd0, boot_timeout}, {7'd0, e_flag});
        if (boot_done === 1'b1) done_seen++;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd(input int len, input bit mm);
        for (int i = 0; i < len; i++) cyc(1'b0, 1'b1, 1'b0, mm);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wr(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        bytes_m[0] = 8'hC3;
        bytes_m[1] = JT[7:0];
        bytes_m[2] = JT[15:8];

        // Normal three-read jump sequence
        do_reset();
        done_seen = 0;
        rd(3, 1'b1); idle(1);
        rd(3, 1'b0); idle(1);
        rd(3, 1'b0);
        chk("seq_reset_cs", {7'd0, reset_cs}, 8'd1);
        idle(2);
        chk("seq_done_pulses", 8'(done_seen), 8'd1);

        // memwrite and reads while released
        wr(5);
        rd(3, 1'b1);
        chk("run_hold", {7'd0, reset_cs}, 8'd1);

        // Non-M1 first read is ignored, then M1 read advances
        do_reset();
        rd(3, 1'b0); idle(1);
        chk("nom1_ovr", override_data, 8'hC3);
        rd(3, 1'b1); idle(1);
        chk("m1_ovr", override_data, JT[7:0]);

        // 1-clock glitch is discarded, 2-clock read advances
        do_reset();
        rd(1, 1'b1); idle(1);
        chk("glitch_ovr", override_data, 8'hC3);
        rd(2, 1'b1); idle(1);
        chk("min_read_ovr", override_data, JT[7:0]);

        // memwrite in OP then timeout with no reads
        do_reset();
        done_seen = 0;
        wr(5);
        idle(TO + 3);
        chk("tmo_flag", {7'd0, boot_timeout}, 8'd1);
        chk("tmo_no_done", 8'(done_seen), 8'd0);
        do_reset();
        chk("tmo_cleared", {7'd0, boot_timeout}, 8'd0);

        // Reset while in HI, then full sequence again
        rd(3, 1'b1); rd(3, 1'b0); idle(1);
        chk("in_hi_ovr", override_data, JT[15:8]);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("mid_reset_cs", {7'd0, reset_cs}, 8'd0);
        chk("mid_reset_ovr", override_data, 8'hC3);
        rd(3, 1'b1); rd(3, 1'b0);
        chk("partial_no_release", {7'd0, reset_cs}, 8'd0);
        rd(3, 1'b0);
        chk("full_release", {7'd0, reset_cs}, 8'd1);

        // Randomized traffic incl. back-to-back reads, overlaps and resets
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit r, mr, mw, mm;
            r  = ($urandom_range(0, 99) < 2);
            mr = ($urandom_range(0, 99) < 55);
            mw = ($urandom_range(0, 99) < 20);
            mm = ($urandom_range(0, 99) < 60);
            cyc(r, mr, mw, mm);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
